ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_pkg.sv | 22 ++
 rtl/ram_fifo_ctrl_fifo_ptr.sv | 44 ++++
 rtl/ram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | ram_fifo_ctrl_pkg : shared defaults and status-flag bit positions    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ram_fifo_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  // Bit positions used when the FIFO flags are mapped into a status register
  localparam int STAT_EMPTY_BIT     = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_AFULL_BIT     = 2;
  localparam int STAT_OVERFLOW_BIT  = 3;
  localparam int STAT_UNDERFLOW_BIT = 4;
  localparam int STAT_W             = 5;

endpackage

`default_nettype wire

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// +----------------------------------------------------------------------+
// | fifo_ptr : modulo-DEPTH pointer with increment enable and sync clear |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_ptr
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // DEPTH is a power of two, so natural binary overflow gives the wrap
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// +----------------------------------------------------------------------+
// | ram_fifo_ctrl : FIFO controller for an external RAM (1-cycle read)   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_LVL = 2**ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_afull,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_ram_wr_en,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_ok, pop_ok;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  assign o_full  = (count_q == DEPTH_CNT);
  assign o_empty = (count_q == '0);
  assign o_afull = (32'(count_q) >= 32'(AFULL_LVL));

  // Acceptance uses only registered flags, so read and write never share an address
  assign push_ok = i_push & ~o_full  & ~i_clr;
  assign pop_ok  = i_pop  & ~o_empty & ~i_clr;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (i_clr),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (i_clr),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    valid_d = pop_ok;
    ovf_d   = ovf_q | (i_push & o_full);
    unf_d   = unf_q | (i_pop & o_empty);
    if (i_clr) begin
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_count       = count_q;
  assign o_valid       = valid_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;
  assign o_data        = i_ram_rd_data;

  assign o_ram_wr_en   = push_ok;
  assign o_ram_wr_addr = wr_ptr;
  assign o_ram_wr_data = i_data;
  assign o_ram_rd_en   = pop_ok;
  assign o_ram_rd_addr = rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_ram_fifo_ctrl : self-checking bench, 4-deep FIFO over a RAM model |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_clr = 1'b0, i_push = 1'b0, i_pop = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_full, o_afull, o_valid, o_empty, o_overflow, o_underflow;
  logic [DW-1:0] o_data, o_ram_wr_data, ram_rd_data;
  logic [AW:0]   o_count;
  logic          o_ram_wr_en, o_ram_rd_en;
  logic [AW-1:0] o_ram_wr_addr, o_ram_rd_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_LVL(AFL)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_push(i_push), .i_data(i_data),
    .o_full(o_full), .o_afull(o_afull), .i_pop(i_pop), .o_data(o_data),
    .o_valid(o_valid), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr),
    .o_ram_wr_data(o_ram_wr_data), .o_ram_rd_en(o_ram_rd_en),
    .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(ram_rd_data)
  );

  // RAM: registered read address, combinational array read
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_rd_addr_q = '0;
  always @(posedge clk) begin
    if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
    if (o_ram_rd_en) ram_rd_addr_q <= o_ram_rd_addr;
  end
  assign ram_rd_data = mem[ram_rd_addr_q];

  // Reference model: a queue of stored words plus totals of accepted transfers
  logic [DW-1:0] mq[$];
  int            wr_tot = 0, rd_tot = 0;
  logic          m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wr_tot = 0; rd_tot = 0;
    m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_state();
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("full", o_full, mq.size() == DEPTH);
    chk("empty", o_empty, mq.size() == 0);
    chk("afull", o_afull, mq.size() >= AFL);
    chk("valid", o_valid, m_valid);
    if (m_valid) chk("data", o_data, m_data);
    chk("overflow", o_overflow, m_ovf);
    chk("underflow", o_underflow, m_unf);
  endtask

  task automatic step(input logic c, input logic p, input logic q, input logic [DW-1:0] d);
    logic m_full, m_empty, pok, qok;
    @(negedge clk);
    i_clr = c; i_push = p; i_pop = q; i_data = d;
    #1;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    pok = p && !c && !m_full;
    qok = q && !c && !m_empty;
    chk("ram_wr_en", o_ram_wr_en, pok);
    if (pok) begin
      chk("ram_wr_addr", o_ram_wr_addr, wr_tot % DEPTH);
      chk("ram_wr_data", o_ram_wr_data, d);
    end
    chk("ram_rd_en", o_ram_rd_en, qok);
    if (qok) chk("ram_rd_addr", o_ram_rd_addr, rd_tot % DEPTH);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      if (p && m_full) m_ovf = 1'b1;
      if (q && m_empty) m_unf = 1'b1;
      m_valid = qok;
      if (qok) begin m_data = mq.pop_front(); rd_tot++; end
      if (pok) begin mq.push_back(d); wr_tot++; end
    end
    check_state();
  endtask

  typedef struct {
    logic clr, push, pop;
    logic [DW-1:0] din;
    int   cnt;
    logic full, afull, empty, valid;
    logic [DW-1:0] dout;
    logic ovf, unf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    //            clr  psh  pop  din     cnt full af  emp val dout   ovf unf
    tbl[0]  = '{1'b0,1'b1,1'b0,8'hA1, 1, 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,8'hA2, 2, 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,8'hA3, 3, 1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,8'hA4, 4, 1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,8'hFF, 4, 1'b1,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,8'h00, 3, 1'b0,1'b1,1'b0,1'b1,8'hA1,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,8'h00, 2, 1'b0,1'b0,1'b0,1'b1,8'hA2,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,8'h00, 1, 1'b0,1'b0,1'b0,1'b1,8'hA3,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,1'b1,1'b1,8'hA4,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,1'b1};
    tbl[10] = '{1'b1,1'b0,1'b0,8'h00, 0, 1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,1'b0};

    // Reset state while rst is held low
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_full", o_full, 1'b0);
    chk("rst_afull", o_afull, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_unf", o_underflow, 1'b0);
    rst = 1'b1;

    // Fill, overflow, drain, underflow, clear
    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].push, tbl[i].pop, tbl[i].din);
      chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), o_full, tbl[i].full);
      chk($sformatf("tbl%0d_afull", i), o_afull, tbl[i].afull);
      chk($sformatf("tbl%0d_empty", i), o_empty, tbl[i].empty);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), o_data, tbl[i].dout);
      chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), o_underflow, tbl[i].unf);
    end

    // Simultaneous push/pop at count 2 across pointer wrap
    step(0, 1, 0, 8'hB0);
    step(0, 1, 0, 8'hB1);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1, 8'hC0 + 8'(k));
      chk("pp_count", 32'(o_count), 2);
      chk("pp_data", o_data, (k == 0) ? 8'hB0 : (k == 1) ? 8'hB1 : 8'hC0 + 8'(k - 2));
    end
    step(1, 0, 0, 8'h00);

    // Push then pop on the next cycle
    step(0, 1, 0, 8'h55);
    step(0, 0, 1, 8'h00);
    chk("lat_valid", o_valid, 1'b1);
    chk("lat_data", o_data, 8'h55);

    // Async reset with a pop in flight
    step(0, 1, 0, 8'h31);
    step(0, 1, 0, 8'h32);
    step(0, 1, 0, 8'h33);
    step(0, 0, 1, 8'h00);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_empty", o_empty, 1'b1);
    chk("arst_count", 32'(o_count), 0);
    model_reset();
    @(negedge clk);
    i_pop = 1'b0;
    rst = 1'b1;
    step(0, 1, 0, 8'h12);
    step(0, 0, 1, 8'h00);
    chk("arst_rd_data", o_data, 8'h12);

    // Clear beats concurrent push and pop
    step(0, 1, 0, 8'h41);
    step(0, 1, 0, 8'h42);
    step(0, 1, 0, 8'h43);
    step(1, 1, 1, 8'h44);
    chk("clr_count", 32'(o_count), 0);
    chk("clr_valid", o_valid, 1'b0);

    // Randomized traffic with alternating fill/drain bias
    for (int n = 0; n < 400; n++) begin
      int pp;
      pp = ((n / 40) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < pp,
           $urandom_range(0, 99) < (100 - pp),
           8'($urandom));
    end

    @(negedge clk);
    i_push = 1'b0; i_pop = 1'b0; i_clr = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
